// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, variable-latency memory between instruction fetch (read-only)
// and the data stage. Data accesses normally win, but a starvation counter forces a
// waiting fetch through after STARVE_MAX consecutive data grants. Every access runs
// IDLE -> *_ACC -> RESP -> IDLE, so only one access is ever outstanding.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          pipe_stall
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IF_ACC = 2'd1;
    localparam logic [1:0] DM_ACC = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int            CW           = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);
    localparam logic [CW-1:0] STARVE_ONE   = CW'(1);

    // The memory is word addressed; the two byte-offset bits are always cleared.
    localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

    logic [1:0]    state;
    logic [CW-1:0] starve_cnt;
    logic          grant_dm;
    logic          grant_if;

    // Arbitration is only meaningful in IDLE: data wins unless a fetch has already
    // been passed over STARVE_MAX times in a row.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE) begin
            grant_dm = dm_req & (~if_req | (starve_cnt < STARVE_LIMIT));
            grant_if = if_req & ~grant_dm;
        end
    end

    // A requester is stalled from the moment it asks until its done pulse is visible.
    assign pipe_stall = (if_req & ~if_done) | (dm_req & ~dm_done);

    // Count data grants that jumped ahead of a waiting fetch; any IF grant or an IDLE
    // cycle without a fetch request clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_dm && if_req) begin
                if (starve_cnt != STARVE_LIMIT) begin
                    starve_cnt <= starve_cnt + STARVE_ONE;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Access sequencer: latch the winner onto the memory bus, hold it until mem_ack,
    // capture read data, then give the owner a single-cycle done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= DM_ACC;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr & WORD_MASK;
                        mem_wdata <= dm_wdata;
                    end else if (grant_if) begin
                        state     <= IF_ACC;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr & WORD_MASK;
                        mem_wdata <= '0;
                    end
                end
                IF_ACC: begin
                    if (mem_ack) begin
                        if_rdata <= mem_rdata;
                        mem_req  <= 1'b0;
                        if_done  <= 1'b1;
                        state    <= RESP;
                    end
                end
                DM_ACC: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        dm_done <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by a randomized run. The bench plays both pipeline
// requesters and the memory (a word-indexed associative array answering after a
// configurable or random number of wait cycles). Expected grants come from the
// priority/starvation rule applied per transaction; expected data from the array.
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;

    logic          clock;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          pipe_stall;

    mem_port_arbiter #(
        .AW(AW),
        .DW(DW),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_rdata(if_rdata),
        .if_done(if_done),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata),
        .dm_done(dm_done),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .pipe_stall(pipe_stall)
    );

    int          check_count = 0;
    int          error_count = 0;
    int          cycle_num   = 0;
    logic [31:0] mem_model [logic [31:0]];
    bit          rand_wait   = 1'b0;
    bit          ack_driven  = 1'b0;
    bit          resp_busy   = 1'b0;
    int          cfg_wait    = 0;
    int          wait_left   = 0;

    // Free-running 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] read_model(input logic [31:0] a);
        if (mem_model.exists(a)) begin
            return mem_model[a];
        end
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr, input logic d_req,
                                 input logic d_we, input logic [31:0] d_addr, input logic [31:0] d_wdata);
        if_req   = i_req;
        if_addr  = i_addr;
        dm_req   = d_req;
        dm_we    = d_we;
        dm_addr  = d_addr;
        dm_wdata = d_wdata;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cycle_num++;
    endtask

    // Memory side: ack one cycle after the wait count expires, drop ack the next cycle.
    task automatic mem_respond();
        if (ack_driven) begin
            mem_ack    = 1'b0;
            ack_driven = 1'b0;
        end else if (mem_req) begin
            if (!resp_busy) begin
                resp_busy = 1'b1;
                wait_left = rand_wait ? int'($urandom_range(0, 3)) : cfg_wait;
            end
            if (wait_left == 0) begin
                mem_ack    = 1'b1;
                ack_driven = 1'b1;
                resp_busy  = 1'b0;
                if (mem_we) begin
                    mem_model[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = read_model(mem_addr);
                end
            end else begin
                wait_left--;
            end
        end
    endtask

    task automatic tick_resp();
        tick();
        mem_respond();
    endtask

    // Whole test sequence: directed scenarios, then randomized traffic, then summary.
    initial begin
        int          n;
        bit          prev;
        logic [9:0]  got_seq;
        int          if_cnt;
        int          dm_cnt;
        int          req_cycles;
        int          done_cycles;
        logic [31:0] prev_rdata;
        logic        exp_if_done;
        logic        exp_dm_done;
        int          done_due;
        int          grant_kind;
        int          starve_model;
        bit          req_prev;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_data;
        logic [31:0] pending_data;
        logic [31:0] exp_dm_rdata;
        bit          was_acked;
        int          if_age;
        int          dm_age;
        bit          abort_run;

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_ctrl", 96'({mem_req, mem_we, if_done, dm_done, pipe_stall}), 96'(5'b0));
        checkOutput("rst_mem_addr", 96'(mem_addr), 96'(32'h0));
        checkOutput("rst_mem_wdata", 96'(mem_wdata), 96'(32'h0));
        checkOutput("rst_rdata", 96'({if_rdata, dm_rdata}), 96'(64'h0));
        reset = 1'b0;
        tick();

        // 1: single fetch, zero waits
        $display("[TB] single fetch");
        cfg_wait = 0;
        mem_model[32'h40] = 32'h2008_0005;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("t1_stall_t", 96'(pipe_stall), 96'(1'b1));
        tick_resp();
        checkOutput("t1_mem_req", 96'({mem_req, mem_we, if_done}), 96'(3'b100));
        checkOutput("t1_mem_addr", 96'(mem_addr), 96'(32'h40));
        checkOutput("t1_stall_t1", 96'(pipe_stall), 96'(1'b1));
        tick_resp();
        checkOutput("t1_if_done", 96'({if_done, dm_done, mem_req}), 96'(3'b100));
        checkOutput("t1_if_rdata", 96'(if_rdata), 96'(32'h2008_0005));
        checkOutput("t1_stall_t2", 96'(pipe_stall), 96'(1'b0));
        if_req = 1'b0;
        tick_resp();
        checkOutput("t1_done_pulse", 96'({if_done, dm_done, mem_req}), 96'(3'b000));

        // 2: simultaneous requests, data first
        $display("[TB] simultaneous requests");
        mem_model[32'h10] = 32'h1111_2222;
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h10, 32'h0);
        tick_resp();
        checkOutput("t2_dm_first", 96'({mem_req, mem_addr}), 96'({1'b1, 32'h10}));
        tick_resp();
        checkOutput("t2_dm_done", 96'({if_done, dm_done}), 96'(2'b01));
        checkOutput("t2_dm_rdata", 96'(dm_rdata), 96'(32'h1111_2222));
        dm_req = 1'b0;
        tick_resp();
        checkOutput("t2_gap", 96'({mem_req, if_done, dm_done}), 96'(3'b000));
        tick_resp();
        checkOutput("t2_if_grant", 96'({mem_req, mem_addr}), 96'({1'b1, 32'h44}));
        tick_resp();
        checkOutput("t2_if_done", 96'({if_done, dm_done}), 96'(2'b10));
        checkOutput("t2_if_rdata", 96'(if_rdata), 96'(read_model(32'h44)));
        if_req = 1'b0;
        tick_resp();

        // 3: both held continuously; fetch gets every fifth grant
        $display("[TB] starvation limit");
        cfg_wait = 1;
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 32'h14, 32'h0);
        got_seq = '0;
        n       = 0;
        prev    = mem_req;
        for (int c = 0; c < 200 && n < 10; c++) begin
            tick_resp();
            if (mem_req && !prev) begin
                got_seq[n] = (mem_addr == 32'h80);
                n++;
            end
            prev = mem_req;
        end
        checkOutput("t3_grant_count", 96'(n), 96'(10));
        checkOutput("t3_grant_order", 96'(got_seq), 96'(10'b10_0001_0000));
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        if_cnt = 0;
        dm_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick_resp();
            if (if_done) if_cnt++;
            if (dm_done) dm_cnt++;
        end
        checkOutput("t3_drop_done", 96'({if_cnt, dm_cnt}), 96'({32'd1, 32'd0}));

        // 4: unaligned store with three wait cycles
        $display("[TB] store with waits");
        cfg_wait    = 3;
        prev_rdata  = read_model(32'h14);
        req_cycles  = 0;
        done_cycles = 0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h13, 32'hDEAD_BEEF);
        for (int c = 0; c < 10; c++) begin
            tick_resp();
            if (mem_req) begin
                req_cycles++;
                checkOutput("t4_bus", 96'({mem_we, mem_addr, mem_wdata}), 96'({1'b1, 32'h10, 32'hDEAD_BEEF}));
            end
            if (dm_done) begin
                done_cycles++;
                dm_req = 1'b0;
                checkOutput("t4_rdata_kept", 96'(dm_rdata), 96'(prev_rdata));
            end
        end
        checkOutput("t4_req_cycles", 96'(req_cycles), 96'(4));
        checkOutput("t4_done_cycles", 96'(done_cycles), 96'(1));

        // 5: reset lands on the same cycle as mem_ack of a data access
        $display("[TB] reset during access");
        cfg_wait = 0;
        mem_model[32'h20] = 32'h0BAD_F00D;
        applyStimulus(1'b1, 32'h84, 1'b1, 1'b0, 32'h20, 32'h0);
        n    = 0;
        prev = mem_req;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (mem_req && !prev) n++;
            prev = mem_req;
            if (n == 4) break;
            mem_respond();
        end
        checkOutput("t5_fourth_dm", 96'({n, mem_req, mem_addr}), 96'({32'd4, 1'b1, 32'h20}));
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        reset     = 1'b1;
        tick();
        checkOutput("t5_reset_wins", 96'({mem_req, dm_done, if_done}), 96'(3'b000));
        checkOutput("t5_no_capture", 96'({dm_rdata, mem_addr}), 96'(64'h0));
        reset      = 1'b0;
        mem_ack    = 1'b0;
        ack_driven = 1'b0;
        resp_busy  = 1'b0;
        tick();
        checkOutput("t5_starve_cleared", 96'({mem_req, dm_done, mem_addr}), 96'({1'b1, 1'b0, 32'h20}));
        mem_respond();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick_resp();
        checkOutput("t5_dropped_done", 96'({dm_done, dm_rdata}), 96'({1'b1, 32'h0BAD_F00D}));
        tick_resp();

        // 6: idle bus
        $display("[TB] idle bus");
        for (int c = 0; c < 10; c++) begin
            tick_resp();
            checkOutput("t6_idle", 96'({mem_req, pipe_stall, if_done, dm_done}), 96'(4'b0000));
        end

        // Randomized traffic against the transaction-level model
        $display("[TB] random traffic");
        rand_wait    = 1'b1;
        done_due     = 0;
        grant_kind   = 0;
        starve_model = 0;
        req_prev     = mem_req;
        exp_addr     = '0;
        exp_we       = 1'b0;
        exp_data     = '0;
        exp_dm_rdata = 32'h0BAD_F00D;
        if_age       = 0;
        dm_age       = 0;
        abort_run    = 1'b0;
        for (int c = 0; c < 3000 && !abort_run; c++) begin
            tick();
            exp_if_done = (done_due == 1);
            exp_dm_done = (done_due == 2);
            checkOutput("rnd_done", 96'({if_done, dm_done}), 96'({exp_if_done, exp_dm_done}));
            checkOutput("rnd_stall", 96'(pipe_stall), 96'((if_req & ~exp_if_done) | (dm_req & ~exp_dm_done)));
            if (done_due == 1) begin
                checkOutput("rnd_if_rdata", 96'(if_rdata), 96'(exp_data));
                if_req = 1'b0;
                if_age = 0;
            end else if (done_due == 2) begin
                if (dm_we) begin
                    checkOutput("rnd_store_rdata", 96'(dm_rdata), 96'(exp_dm_rdata));
                end else begin
                    exp_dm_rdata = exp_data;
                    checkOutput("rnd_load_rdata", 96'(dm_rdata), 96'(exp_data));
                end
                dm_req = 1'b0;
                dm_age = 0;
            end
            done_due = 0;

            if (mem_req && !req_prev) begin
                if (!if_req && !dm_req) begin
                    checkOutput("rnd_spurious", 96'(mem_req), 96'(1'b0));
                    grant_kind = 0;
                end else if (dm_req && (!if_req || starve_model < STARVE_MAX)) begin
                    grant_kind = 2;
                    exp_addr   = dm_addr & ~32'h3;
                    exp_we     = dm_we;
                    checkOutput("rnd_dm_wdata", 96'(mem_wdata), 96'(dm_wdata));
                    if (!if_req) starve_model = 0;
                    else if (starve_model < STARVE_MAX) starve_model++;
                end else begin
                    grant_kind   = 1;
                    exp_addr     = if_addr & ~32'h3;
                    exp_we       = 1'b0;
                    starve_model = 0;
                end
            end
            if (mem_req && grant_kind != 0) begin
                checkOutput("rnd_bus", 96'({mem_we, mem_addr}), 96'({exp_we, exp_addr}));
            end
            req_prev = mem_req;

            pending_data = read_model(exp_addr);
            was_acked    = ack_driven;
            mem_respond();
            if (ack_driven && !was_acked) begin
                done_due = grant_kind;
                exp_data = pending_data;
            end

            if (if_req) if_age++;
            if (dm_req) dm_age++;
            if (if_age > 60 || dm_age > 60) begin
                checkOutput("rnd_timeout", 96'({if_age, dm_age}), 96'(0));
                abort_run = 1'b1;
            end

            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h0000_1000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = 32'h0002_0000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
                dm_wdata = $urandom;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
